// File: rtl/alu_nib_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// - alu opcode encodings (l=0), request opcodes, correction operands
// - FSM state encoding and the internal operation class
// - helpers: request opcode decode and signed-overflow evaluation
package alu_nib_seq_pkg;

  localparam logic [1:0] ALUOP_NEGA = 2'b00;
  localparam logic [1:0] ALUOP_NEGB = 2'b01;
  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b11;

  localparam logic [2:0] REQ_ADD = 3'b000;
  localparam logic [2:0] REQ_SUB = 3'b001;
  localparam logic [2:0] REQ_NEG = 3'b010;
  localparam logic [2:0] REQ_RSV = 3'b011;  // behaves as ADD

  // Operand added to a nibble to fold in a carry (+1) or a borrow (-1).
  localparam logic [3:0] CORR_ADD = 4'b0001;
  localparam logic [3:0] CORR_SUB = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAIN,
    ST_CORR,
    ST_DONE
  } state_e;

  // NEG is folded into SUB at accept time, so only three classes remain.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_LOGIC
  } op_cls_e;

  function automatic op_cls_e decode_op(input logic [2:0] op);
    if (op[2]) return CLS_LOGIC;
    if (op == REQ_SUB || op == REQ_NEG) return CLS_SUB;
    return CLS_ADD;
  endfunction

  // Signed overflow: operands (b inverted for subtraction) agree in sign
  // and the result sign differs from them.
  function automatic logic calc_ovf(input op_cls_e cls, input logic sa,
                                    input logic sb, input logic rmsb);
    logic sbe;
    sbe = (cls == CLS_ADD) ? sb : ~sb;
    return (cls != CLS_LOGIC) && (sa == sbe) && (rmsb != sa);
  endfunction

endpackage

// File: rtl/alu_nib_seq_if.sv
// Upstream request/response bus of the nibble-serial ALU sequencer.
// master: request producer / response consumer.
// slave : the sequencer.
//   req_valid/req_ready/req_op/req_a/req_b   request handshake + payload
//   rsp_valid/rsp_ready/rsp_res/rsp_zero/rsp_carry/rsp_sign/rsp_ovf   response
interface alu_nib_seq_if #(
  parameter int NIBBLES = 2
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_op;
  logic [4*NIBBLES-1:0]   req_a;
  logic [4*NIBBLES-1:0]   req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [4*NIBBLES-1:0]   rsp_res;
  logic                   rsp_zero;
  logic                   rsp_carry;
  logic                   rsp_sign;
  logic                   rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_carry, rsp_sign, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_carry, rsp_sign, rsp_ovf
  );

endinterface

// File: rtl/alu_nib_seq_carry_fix.sv
// Carry chaining decision for one nibble pass (combinational).
//   cls_i        operation class of the current request
//   c_i          carry into the current nibble
//   c1_i         registered carry of the main pass of this nibble
//   c2_i         alu carry of the pass being executed right now
//   in_corr_i    1 while executing the correction pass
//   need_corr_o  main pass must be followed by a correction pass
//   c_next_o     carry into the next nibble when the nibble is finished
module alu_nib_seq_carry_fix
  import alu_nib_seq_pkg::*;
(
  input  op_cls_e cls_i,
  input  logic    c_i,
  input  logic    c1_i,
  input  logic    c2_i,
  input  logic    in_corr_i,
  output logic    need_corr_o,
  output logic    c_next_o
);

  // The alu has no carry-in: ADD always runs a+b (carry-in 0) and SUB a+~b+1
  // (carry-in 1). A correction is needed only when the real carry-in differs.
  // A nibble can overflow in the main pass or in the correction, never both,
  // so ADD ORs the two carries; SUB's -1 borrows only when the nibble was 0,
  // so SUB ANDs them.
  always_comb begin
    need_corr_o = 1'b0;
    c_next_o    = 1'b0;
    if (in_corr_i) begin
      c_next_o = (cls_i == CLS_SUB) ? (c1_i & c2_i) : (c1_i | c2_i);
    end else begin
      need_corr_o = ((cls_i == CLS_ADD) && c_i) || ((cls_i == CLS_SUB) && !c_i);
      c_next_o    = (cls_i != CLS_LOGIC) && c2_i;
    end
  end

endmodule

// File: rtl/alu_nib_seq.sv
// Nibble-serial initiator for an external 4-bit combinational alu.
// Runs 4*NIBBLES-bit ADD/SUB/NEG/logic one nibble per cycle, inserting a
// correction pass whenever a carry/borrow has to be folded into a nibble.
//   clk_i, reset_ni       clock, synchronous active-low reset
//   bus (slave)           request/response handshake bus
//   alu_a_o/alu_b_o       alu operands
//   alu_op_o/alu_l_o      alu ALUOp and logic select
//   alu_r_i, alu_zero_i, alu_carry_i, alu_sign_i   alu results (same cycle)
module alu_nib_seq
  import alu_nib_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  alu_nib_seq_if.slave      bus,
  output logic [3:0]        alu_a_o,
  output logic [3:0]        alu_b_o,
  output logic [1:0]        alu_op_o,
  output logic              alu_l_o,
  input  logic [3:0]        alu_r_i,
  input  logic              alu_zero_i,
  input  logic              alu_carry_i,
  input  logic              alu_sign_i
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][3:0] nib_vec_t;

  state_e             state_q;
  op_cls_e            cls_q;
  logic [1:0]         lop_q;
  nib_vec_t           a_q, b_q, res_q;
  logic [NIBBLES-1:0] zero_q;
  logic               sign_q;
  logic               c_q, c1_q;
  logic [IDXW-1:0]    idx_q;
  logic               ovf_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  nib_vec_t           rsp_res_q;
  logic               rsp_zero_q, rsp_carry_q, rsp_sign_q, rsp_ovf_q;

  op_cls_e            req_cls;
  logic               need_corr, c_next;

  assign req_cls = decode_op(bus.req_op);

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_sign  = rsp_sign_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

  // alu drive: operand nibbles in MAIN, registered nibble +/-1 in CORR,
  // a quiet ADD of zeros otherwise.
  always_comb begin
    alu_a_o  = 4'h0;
    alu_b_o  = 4'h0;
    alu_op_o = ALUOP_ADD;
    alu_l_o  = 1'b0;
    case (state_q)
      ST_MAIN: begin
        alu_a_o = a_q[idx_q];
        alu_b_o = b_q[idx_q];
        case (cls_q)
          CLS_SUB:   alu_op_o = ALUOP_SUB;
          CLS_LOGIC: begin
            alu_l_o  = 1'b1;
            alu_op_o = lop_q;
          end
          default:   alu_op_o = ALUOP_ADD;
        endcase
      end
      ST_CORR: begin
        alu_a_o = res_q[idx_q];
        alu_b_o = (cls_q == CLS_SUB) ? CORR_SUB : CORR_ADD;
      end
      default: ;
    endcase
  end

  alu_nib_seq_carry_fix u_carry_fix (
    .cls_i       (cls_q),
    .c_i         (c_q),
    .c1_i        (c1_q),
    .c2_i        (alu_carry_i),
    .in_corr_i   (state_q == ST_CORR),
    .need_corr_o (need_corr),
    .c_next_o    (c_next)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_ADD;
      lop_q       <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      zero_q      <= '0;
      sign_q      <= 1'b0;
      c_q         <= 1'b0;
      c1_q        <= 1'b0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_sign_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            cls_q <= req_cls;
            lop_q <= bus.req_op[1:0];
            // NEG runs as 0 - a.
            if (bus.req_op == REQ_NEG) begin
              a_q <= '0;
              b_q <= bus.req_a;
            end else begin
              a_q <= bus.req_a;
              b_q <= bus.req_b;
            end
            idx_q       <= '0;
            c_q         <= (req_cls == CLS_SUB);
            req_ready_q <= 1'b0;
            state_q     <= ST_MAIN;
          end
        end

        ST_MAIN, ST_CORR: begin
          res_q[idx_q]  <= alu_r_i;
          zero_q[idx_q] <= alu_zero_i;
          sign_q        <= alu_sign_i;
          if (state_q == ST_MAIN) c1_q <= alu_carry_i;
          // need_corr is forced low by carry_fix while in CORR.
          if (need_corr) begin
            state_q <= ST_CORR;
          end else begin
            c_q <= c_next;
            if (idx_q == LAST_IDX) begin
              // alu_r_i is the final value of the top nibble here.
              ovf_q   <= calc_ovf(cls_q, a_q[NIBBLES-1][3], b_q[NIBBLES-1][3],
                                  alu_r_i[3]);
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + IDXW'(1);
              state_q <= ST_MAIN;
            end
          end
        end

        ST_DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!rsp_valid_q) begin
            rsp_res_q   <= res_q;
            rsp_zero_q  <= &zero_q;
            rsp_carry_q <= (cls_q != CLS_LOGIC) && c_q;
            rsp_sign_q  <= sign_q;
            rsp_ovf_q   <= ovf_q;
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nib_seq.sv
// Directed bench for alu_nib_seq (NIBBLES=2) with a behavioural 4-bit alu.
module tb_alu_nib_seq;
  import alu_nib_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_l, alu_zero, alu_carry, alu_sign;
  int         total = 0;
  int         bad = 0;

  alu_nib_seq_if #(.NIBBLES(2)) bus ();

  alu_nib_seq #(.NIBBLES(2)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .bus        (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_op_o   (alu_op),
    .alu_l_o    (alu_l),
    .alu_r_i    (alu_r),
    .alu_zero_i (alu_zero),
    .alu_carry_i(alu_carry),
    .alu_sign_i (alu_sign)
  );

  always #5 clk = ~clk;

  // 4-bit alu: l=0 arithmetic with carry-out, l=1 logic (AND/OR/XOR/NAND).
  always_comb begin
    logic [4:0] s;
    s = 5'd0;
    if (!alu_l) begin
      case (alu_op)
        2'b00:   s = 5'd0 + {1'b0, ~alu_a} + 5'd1;
        2'b01:   s = 5'd0 + {1'b0, ~alu_b} + 5'd1;
        2'b10:   s = {1'b0, alu_a} + {1'b0, alu_b};
        default: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      endcase
    end else begin
      case (alu_op)
        2'b00:   s = {1'b0, alu_a & alu_b};
        2'b01:   s = {1'b0, alu_a | alu_b};
        2'b10:   s = {1'b0, alu_a ^ alu_b};
        default: s = {1'b0, ~(alu_a & alu_b)};
      endcase
    end
    alu_r     = s[3:0];
    alu_carry = s[4];
    alu_zero  = (s[3:0] == 4'h0);
    alu_sign  = s[3];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e_res, input logic e_z,
                        input logic e_c, input logic e_s, input logic e_v, input int e_lat);
    int lat;
    chk({tag, ".req_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    chk({tag, ".lat"},   lat, e_lat);
    chk({tag, ".res"},   bus.rsp_res, e_res);
    chk({tag, ".zero"},  bus.rsp_zero, e_z);
    chk({tag, ".carry"}, bus.rsp_carry, e_c);
    chk({tag, ".sign"},  bus.rsp_sign, e_s);
    chk({tag, ".ovf"},   bus.rsp_ovf, e_v);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, ".vld_clr"}, bus.rsp_valid, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    step();
    step();
    chk("rst.req_ready", bus.req_ready, 1);
    chk("rst.rsp_valid", bus.rsp_valid, 0);
    chk("rst.res", bus.rsp_res, 0);
    chk("rst.alu_op", alu_op, 2'b10);
    reset_n = 1'b1;
    step();

    //      tag       op      a      b      res    z     c     s     v     lat
    run_op("add1",   3'b000, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    run_op("add2",   3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    run_op("add3",   3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 4);
    run_op("rsv",    3'b011, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("sub1",   3'b001, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    run_op("sub2",   3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    run_op("neg1",   3'b010, 8'h01, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    run_op("neg2",   3'b010, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    run_op("and",    3'b100, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("or",     3'b101, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    run_op("xor",    3'b110, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    run_op("nand",   3'b111, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Backpressure: result held, no new request accepted while in DONE.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_a     = 8'h3C;
    bus.req_b     = 8'h05;
    step();
    bus.req_a     = 8'h11;
    bus.req_b     = 8'h22;
    begin
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.valid", bus.rsp_valid, 1);
      chk("bp.res", bus.rsp_res, 8'h41);
      chk("bp.req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp.vld_clr", bus.rsp_valid, 0);
    chk("bp.idle_alu_a", alu_a, 0);

    // Reset while a correction pass is in flight.
    bus.req_valid = 1'b1;
    bus.req_a     = 8'h3C;
    bus.req_b     = 8'h05;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("corr.alu_a", alu_a, 4'h3);
    chk("corr.alu_b", alu_b, 4'h1);
    chk("corr.alu_op", alu_op, 2'b10);
    reset_n = 1'b0;
    step();
    chk("mrst.req_ready", bus.req_ready, 1);
    chk("mrst.rsp_valid", bus.rsp_valid, 0);
    chk("mrst.res", bus.rsp_res, 0);
    chk("mrst.flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_sign, bus.rsp_ovf}, 0);
    chk("mrst.alu_b", alu_b, 0);
    reset_n = 1'b1;
    step();
    run_op("post",   3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
